// File: rtl/mux_4to1_rr.sv
// 4:1 valid/ready stream merger, round-robin arbitration, registered output.
// Define MUX_FIXED_PRIO_EN for fixed priority (source 0 highest).
module mux_4to1_rr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [3:0]       in_valid,
  output logic [3:0]       in_ready,
  output logic [WIDTH-1:0] out,
  output logic [1:0]       out_sel,
  output logic             out_valid,
  input  logic             out_ready
);

  logic             load;
  logic             hit;
  logic [1:0]       gidx;
  logic [1:0]       idx;
  logic [3:0]       gnt;
  logic [WIDTH-1:0] din;

`ifndef MUX_FIXED_PRIO_EN
  logic [1:0] last;
`endif

  assign load = !out_valid || out_ready;

  // Scan from the slot after the last grant, wrapping 3 -> 0.
  always_comb begin
    hit  = 1'b0;
    gidx = 2'd0;
    idx  = 2'd0;
    for (int k = 0; k < 4; k++) begin
`ifdef MUX_FIXED_PRIO_EN
      idx = 2'(k);
`else
      idx = last + 2'(k) + 2'd1;
`endif
      if (!hit && in_valid[idx]) begin
        hit  = 1'b1;
        gidx = idx;
      end
    end
  end

  always_comb begin
    gnt = 4'b0000;
    if (rst_n && load && hit)
      gnt[gidx] = 1'b1;
  end

  assign in_ready = gnt;

  always_comb begin
    din = in0;
    case (gidx)
      2'd1:    din = in1;
      2'd2:    din = in2;
      2'd3:    din = in3;
      default: din = in0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      out_sel   <= 2'd0;
      out_valid <= 1'b0;
`ifndef MUX_FIXED_PRIO_EN
      last      <= 2'd3;
`endif
    end else if (load) begin
      if (hit) begin
        out       <= din;
        out_sel   <= gidx;
        out_valid <= 1'b1;
`ifndef MUX_FIXED_PRIO_EN
        last      <= gidx;
`endif
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_4to1_rr.sv
// Self-checking bench for mux_4to1_rr: directed steps then random traffic
// against a behavioural arbitration model.
module tb_mux_4to1_rr;

  logic       clk;
  logic       rst_n;
  logic [7:0] d [4];
  logic [3:0] in_valid;
  logic [3:0] in_ready;
  logic [7:0] out;
  logic [1:0] out_sel;
  logic       out_valid;
  logic       out_ready;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_out;
  int         m_sel;
  logic       m_valid;
  int         m_last;

  mux_4to1_rr #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in0       (d[0]),
    .in1       (d[1]),
    .in2       (d[2]),
    .in3       (d[3]),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] v, input int last);
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (last + k) % 4;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_out   = 8'h00;
    m_sel   = 0;
    m_valid = 1'b0;
    m_last  = 3;
  endtask

  // Called just after a negedge with inputs already driven.
  task automatic step(input string tag, output int g);
    logic ld;
    logic [31:0] er;
    #1;
    ld = !m_valid || out_ready;
    g  = ld ? pick(in_valid, m_last) : -1;
    er = (g >= 0) ? (32'd1 << g) : 32'd0;
    chk({tag, " in_ready"}, 32'(in_ready), er);
    @(posedge clk);
    if (ld) begin
      if (g >= 0) begin
        m_out   = d[g];
        m_sel   = g;
        m_valid = 1'b1;
`ifndef MUX_FIXED_PRIO_EN
        m_last  = g;
`endif
      end else begin
        m_valid = 1'b0;
      end
    end
    @(negedge clk);
    chk({tag, " out"}, 32'(out), 32'(m_out));
    chk({tag, " out_sel"}, 32'(out_sel), 32'(m_sel));
    chk({tag, " out_valid"}, 32'(out_valid), 32'(m_valid));
  endtask

  task automatic pulse_reset();
    in_valid = 4'b0000;
    rst_n = 1'b0;
    #1;
    model_reset();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int g;
    int exp_sel;
    rst_n     = 1'b0;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33; d[3] = 8'h44;
    model_reset();
    #1;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out", 32'(out), 32'd0);
    chk("reset out_sel", 32'(out_sel), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(negedge clk);
    chk("reset held in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    step("first", g);
    chk("first from src0", 32'(out_sel), 32'd0);

    pulse_reset();
    d[0] = 8'hA0; d[1] = 8'hA1; d[2] = 8'hA2; d[3] = 8'hA3;
    in_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      step("rr", g);
`ifdef MUX_FIXED_PRIO_EN
      exp_sel = 0;
`else
      exp_sel = k % 4;
`endif
      chk("rr seq", 32'(out_sel), 32'(exp_sel));
      chk("rr data", 32'(out), 32'(8'hA0 + exp_sel));
    end

    pulse_reset();
    d[0] = 8'h55;
    in_valid = 4'b0001;
    step("bp load", g);
    in_valid  = 4'b1110;
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step("bp stall", g);
      chk("bp hold", 32'(out), 32'h55);
    end
    out_ready = 1'b1;
    step("bp release", g);
    in_valid[g] = 1'b0;
    step("bp drain", g);

    pulse_reset();
    d[2] = 8'h3C;
    in_valid = 4'b0100;
    step("sparse", g);
    chk("sparse out", 32'(out), 32'h3C);
    in_valid = 4'b0000;
    step("sparse idle", g);
    chk("sparse idle valid", 32'(out_valid), 32'd0);

    pulse_reset();
    in_valid = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      step("wrap", g);
`ifdef MUX_FIXED_PRIO_EN
      exp_sel = 1;
`else
      exp_sel = (k == 1) ? 3 : 1;
`endif
      chk("wrap seq", 32'(out_sel), 32'(exp_sel));
    end

    in_valid  = 4'b0001;
    out_ready = 1'b1;
    step("ar load", g);
    out_ready = 1'b0;
    in_valid  = 4'b1111;
    step("ar stall", g);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar out_valid", 32'(out_valid), 32'd0);
    chk("ar in_ready", 32'(in_ready), 32'd0);
    model_reset();
    in_valid  = 4'b0000;
    out_ready = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    in_valid = 4'b1111;
    step("ar after", g);
    chk("ar src0 first", 32'(out_sel), 32'd0);

    pulse_reset();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++)
        if (!in_valid[i] && $urandom_range(0, 2) == 0) begin
          in_valid[i] = 1'b1;
          d[i] = 8'($urandom);
        end
      out_ready = ($urandom_range(0, 3) != 0);
      step("rand", g);
      if (g >= 0) in_valid[g] = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
